// File: rtl/fan_speed_ctrl.sv
// fan_speed_ctrl: hysteretic 4-level fan controller with sticky over-temperature alarm,
// driving a flex counter's fan_speed/sign/rollover_val/seed from sampled temperature.
module fan_speed_ctrl #(
  parameter int         T_LOW      = 40,
  parameter int         T_MID      = 60,
  parameter int         T_HIGH     = 80,
  parameter int         HYST       = 4,
  parameter int         T_CRIT     = 100,
  parameter int         CRIT_COUNT = 3,
  parameter int         DWELL      = 4,
  parameter int         ROLL_VAL   = 50,
  parameter logic [3:0] SEED_INIT  = 4'h5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [6:0] temperature,
  input  logic       rollover_flag,
  output logic [1:0] fan_speed,
  output logic       sign,
  output logic [6:0] rollover_val,
  output logic [3:0] seed,
  output logic       alarm,
  output logic [2:0] state_dbg
);
  typedef enum logic [2:0] {LVL0 = 3'd0, LVL1 = 3'd1, LVL2 = 3'd2, LVL3 = 3'd3, ALARM = 3'd4} state_t;
  localparam int CMAX = DWELL > CRIT_COUNT ? DWELL : CRIT_COUNT;
  localparam int CW = $clog2(CMAX + 1);
  localparam logic [6:0] TU1 = 7'(T_LOW);
  localparam logic [6:0] TU2 = 7'(T_MID);
  localparam logic [6:0] TU3 = 7'(T_HIGH);
  localparam logic [6:0] TD1 = 7'(T_LOW - HYST);
  localparam logic [6:0] TD2 = 7'(T_MID - HYST);
  localparam logic [6:0] TD3 = 7'(T_HIGH - HYST);
  localparam logic [6:0] TC  = 7'(T_CRIT);
  localparam logic [6:0] RV  = 7'(ROLL_VAL);
  localparam logic [6:0] RVH = 7'(ROLL_VAL / 2);
  localparam logic [CW-1:0] CC  = CW'(CRIT_COUNT);
  localparam logic [CW-1:0] DW1 = CW'(DWELL - 1);
  state_t          state_q, state_d;
  logic [CW-1:0]   dwell_q, dwell_d, crit_q, crit_d;
  logic [3:0]      seed_q, seed_d;
  logic [1:0]      fan_q, fan_d, lvl;
  logic            sign_q, alarm_q, alarm_d;
  logic [6:0]      rv_q, rv_d, up_th, dn_th;
  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    crit_d  = crit_q;
    seed_d  = seed_q;
    lvl     = state_q[1:0];
    up_th   = lvl == 2'd0 ? TU1 : lvl == 2'd1 ? TU2 : TU3;
    dn_th   = lvl == 2'd1 ? TD1 : lvl == 2'd2 ? TD2 : TD3;
    if (!enable) begin
      dwell_d = '0;
      crit_d  = '0;
    end else if (rollover_flag) begin
      if (state_q == ALARM) begin
        dwell_d = '0;
        crit_d  = '0;
        if (temperature < TD3) state_d = LVL3;
      end else begin
        crit_d  = temperature >= TC ? (crit_q == CC ? crit_q : crit_q + 1'b1) : '0;
        dwell_d = '0;
        // alarm entry outranks step up, which outranks step down
        if (crit_d == CC) begin
          state_d = ALARM;
          seed_d  = seed_q + 4'd1;
        end else if (lvl != 2'd3 && temperature >= up_th) begin
          state_d = state_t'(state_q + 3'd1);
        end else if (lvl != 2'd0 && temperature < dn_th) begin
          if (dwell_q == DW1) state_d = state_t'(state_q - 3'd1);
          else dwell_d = dwell_q + 1'b1;
        end
      end
    end
    alarm_d = state_d == ALARM;
    fan_d   = alarm_d ? 2'd3 : state_d[1:0];
    rv_d    = alarm_d ? RVH : RV;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LVL0;
      dwell_q <= '0;
      crit_q  <= '0;
      seed_q  <= SEED_INIT;
      fan_q   <= 2'd0;
      sign_q  <= 1'b0;
      alarm_q <= 1'b0;
      rv_q    <= RV;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      crit_q  <= crit_d;
      seed_q  <= seed_d;
      fan_q   <= fan_d;
      sign_q  <= fan_d[1];
      alarm_q <= alarm_d;
      rv_q    <= rv_d;
    end
  end
  assign fan_speed    = fan_q;
  assign sign         = sign_q;
  assign alarm        = alarm_q;
  assign rollover_val = rv_q;
  assign seed         = seed_q;
  assign state_dbg    = state_q;
endmodule

// File: tb/tb_fan_speed_ctrl.sv
// tb_fan_speed_ctrl: scenario tasks plus a random walk, checked against a level/alarm
// reference model of the fan controller.
module tb_fan_speed_ctrl;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b0;
  logic [6:0] temperature = '0;
  logic       rollover_flag = 1'b0;
  logic [1:0] fan_speed;
  logic       sign;
  logic [6:0] rollover_val;
  logic [3:0] seed;
  logic       alarm;
  logic [2:0] state_dbg;
  int total = 0;
  int bad = 0;
  int m_lvl, m_alarm, m_dwell, m_crit, m_seed;
  int th [4] = '{0, 40, 60, 80};
  logic [17:0] obs, expv;

  fan_speed_ctrl dut (
    .clk(clk), .rst(rst), .enable(enable), .temperature(temperature),
    .rollover_flag(rollover_flag), .fan_speed(fan_speed), .sign(sign),
    .rollover_val(rollover_val), .seed(seed), .alarm(alarm), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_lvl = 0; m_alarm = 0; m_dwell = 0; m_crit = 0; m_seed = 5;
  endtask

  task automatic model_sample(input int t);
    if (m_alarm != 0) begin
      if (t < th[3] - 4) begin m_alarm = 0; m_lvl = 3; end
    end else begin
      m_crit = (t >= 100) ? ((m_crit + 1 > 3) ? 3 : m_crit + 1) : 0;
      if (m_crit == 3) begin
        m_alarm = 1; m_seed = (m_seed + 1) % 16; m_crit = 0; m_dwell = 0;
      end else if (m_lvl < 3 && t >= th[m_lvl + 1]) begin
        m_lvl++; m_dwell = 0;
      end else if (m_lvl > 0 && t < th[m_lvl] - 4) begin
        m_dwell++;
        if (m_dwell == 4) begin m_lvl--; m_dwell = 0; end
      end else m_dwell = 0;
    end
  endtask

  function automatic logic [17:0] exp_vec();
    int f;
    f = (m_alarm != 0) ? 3 : m_lvl;
    return {2'(f), f >= 2, m_alarm != 0, (m_alarm != 0) ? 7'd25 : 7'd50, 4'(m_seed),
            (m_alarm != 0) ? 3'd4 : 3'(m_lvl)};
  endfunction

  // called at a negedge; leaves at the following negedge
  task automatic sample(input int t, input bit en, input bit fl);
    temperature = 7'(t); enable = en; rollover_flag = fl;
    @(posedge clk);
    if (!en) begin m_dwell = 0; m_crit = 0; end
    else if (fl) model_sample(t);
    @(negedge clk);
    rollover_flag = 1'b0; enable = 1'b1;
    obs = {fan_speed, sign, alarm, rollover_val, seed, state_dbg};
    expv = exp_vec();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    model_reset();
    obs = {fan_speed, sign, alarm, rollover_val, seed, state_dbg};
    total++;
    if (obs !== exp_vec() || obs !== {2'd0, 1'b0, 1'b0, 7'd50, 4'd5, 3'd0}) begin
      bad++; $display("FAIL reset: got %h want %h", obs, exp_vec());
    end
    rst = 1'b0; enable = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ramp();
    int temps [3] = '{45, 65, 85};
    for (int i = 0; i < 3; i++) begin
      sample(temps[i], 1, 1);
      total++;
      if (obs !== expv || fan_speed !== 2'(i + 1) || sign !== (i >= 1)) begin
        bad++; $display("FAIL ramp%0d: got %h want %h", i, obs, expv);
      end
    end
    for (int i = 0; i < 4; i++) begin
      sample(70, 1, 1);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL ramp_down%0d: got %h want %h", i, obs, expv); end
    end
  endtask

  task automatic test_hysteresis();
    int temps [17] = '{57, 57, 57, 57, 57, 57, 55, 55, 55, 55, 55, 55, 55, 57, 55, 55, 55};
    for (int i = 0; i < 17; i++) begin
      sample(temps[i], 1, 1);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL hyst%0d: got %h want %h", i, obs, expv); end
    end
    total++;
    if (fan_speed !== 2'd1) begin bad++; $display("FAIL hyst_final: got %0d want 1", fan_speed); end
  endtask

  task automatic test_alarm();
    int temps [6] = '{100, 101, 99, 100, 100, 100};
    for (int i = 0; i < 6; i++) begin
      sample(temps[i], 1, 1);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL alarm_in%0d: got %h want %h", i, obs, expv); end
    end
    total++;
    if ({alarm, fan_speed, rollover_val, seed} !== {1'b1, 2'd3, 7'd25, 4'd6}) begin
      bad++; $display("FAIL alarm_entry: got %h want %h", {alarm, fan_speed, rollover_val, seed},
                      {1'b1, 2'd3, 7'd25, 4'd6});
    end
    sample(80, 1, 1);
    total++;
    if (obs !== expv || alarm !== 1'b1) begin bad++; $display("FAIL alarm_hold: got %h want %h", obs, expv); end
    sample(75, 1, 1);
    total++;
    if (obs !== expv || {alarm, state_dbg, rollover_val, seed} !== {1'b0, 3'd3, 7'd50, 4'd6}) begin
      bad++; $display("FAIL alarm_exit: got %h want %h", obs, expv);
    end
  endtask

  task automatic test_gating();
    pulse_reset();
    for (int i = 0; i < 3; i++) begin
      sample(90, 0, 1);
      total++;
      if (obs !== expv || state_dbg !== 3'd0) begin bad++; $display("FAIL gate_en%0d: got %h want %h", i, obs, expv); end
    end
    sample(90, 1, 0);
    total++;
    if (obs !== expv || state_dbg !== 3'd0) begin bad++; $display("FAIL gate_flag: got %h want %h", obs, expv); end
    sample(90, 1, 1);
    total++;
    if (obs !== expv || state_dbg !== 3'd1) begin bad++; $display("FAIL gate_step: got %h want %h", obs, expv); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) sample(100, 1, 1);
    total++;
    if (obs !== expv || alarm !== 1'b1) begin bad++; $display("FAIL b2b_alarm: got %h want %h", obs, expv); end
  endtask

  task automatic test_async_reset();
    #3 rst = 1'b1;
    #1;
    model_reset();
    obs = {fan_speed, sign, alarm, rollover_val, seed, state_dbg};
    total++;
    if (obs !== exp_vec()) begin bad++; $display("FAIL async_reset: got %h want %h", obs, exp_vec()); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_random();
    int t = 50;
    for (int i = 0; i < 600; i++) begin
      t = t + int'($urandom_range(0, 12)) - 6;
      if ($urandom_range(0, 29) == 0) t = int'($urandom_range(0, 127));
      if (t < 0) t = 0;
      if (t > 127) t = 127;
      sample(t, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0);
      total++;
      if (obs !== expv) begin bad++; $display("FAIL random%0d: got %h want %h", i, obs, expv); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_ramp();
    test_hysteresis();
    test_alarm();
    test_gating();
    test_back_to_back();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/fan_speed_ctrl.md
Name: fan_speed_ctrl

Overview:
- Closed-loop thermal controller for the flex-counter thermal model.
- Samples `temperature` on each counter rollover and drives the counter's `fan_speed` and `sign` inputs through a 4-level hysteretic state machine.
- Configures the counter's `rollover_val` (sample period) and `seed`.
- Raises a sticky over-temperature alarm after sustained critical readings.

Parameters:
- T_LOW, 40, temperature at or above which level 0 steps up to level 1
- T_MID, 60, level 1 -> 2 step-up threshold
- T_HIGH, 80, level 2 -> 3 step-up threshold
- HYST, 4, hysteresis; step down from level k occurs below T_k - HYST (T_1=T_LOW, T_2=T_MID, T_3=T_HIGH)
- T_CRIT, 100, critical temperature
- CRIT_COUNT, 3, consecutive samples >= T_CRIT required to enter ALARM
- DWELL, 4, consecutive below-threshold samples required before one step down
- ROLL_VAL, 50, normal sample period written to `rollover_val`
- SEED_INIT, 4'h5, `seed` value after reset

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- enable  in  1  controller enable; when low, state is held
- temperature  in  7  unsigned temperature from flex counter
- rollover_flag  in  1  sample strobe from flex counter, 1-cycle pulse
- fan_speed  out  2  fan level 0..3 to flex counter
- sign  out  1  counter direction to flex counter; 1 = cooling (count down)
- rollover_val  out  7  sample period to flex counter
- seed  out  4  seed to flex counter
- alarm  out  1  over-temperature alarm
- state_dbg  out  3  encoded FSM state

Behaviour:
- Single clock. Reset is asynchronous and active-high. All outputs are registered.
- Reset values:
  - FSM state = LVL0; fan_speed=0, sign=0, alarm=0
  - rollover_val=ROLL_VAL, seed=SEED_INIT
  - dwell_cnt=0, crit_cnt=0
- Sample event: `rollover_flag & enable` at a rising edge. All decisions use the `temperature` value at that edge. Outputs reflect the decision on the next edge (1-cycle latency).
- FSM states:
  - LVL0 (code 0), LVL1 (1), LVL2 (2), LVL3 (3), ALARM (4).
  - fan_speed = level for LVLk; fan_speed = 3 in ALARM.
  - state_dbg = state code.
- Step up from LVLk, k<3: if temperature >= T_(k+1), go to LVL(k+1) on that sample and clear dwell_cnt.
  - Step is one level per sample only; e.g. temperature=90 at LVL0 reaches LVL3 after 3 samples.
- Step down from LVLk, k>0: if temperature < T_k - HYST, increment dwell_cnt.
  - When dwell_cnt reaches DWELL, go to LVL(k-1) and clear dwell_cnt.
  - Any sample not below the threshold clears dwell_cnt.
  - LVL0 never steps down.
- Critical detection, evaluated in all LVL states:
  - temperature >= T_CRIT increments crit_cnt (saturating at CRIT_COUNT); otherwise crit_cnt clears.
  - When crit_cnt reaches CRIT_COUNT, enter ALARM regardless of level.
  - Priority when simultaneous: ALARM entry > step up > step down.
- ALARM:
  - alarm=1, rollover_val=ROLL_VAL>>1 (faster sampling).
  - seed increments by 1 (mod 16) once on each ALARM entry.
  - Exits to LVL3 on the first sample with temperature < T_HIGH - HYST. On exit: alarm=0, rollover_val=ROLL_VAL, crit_cnt=0, dwell_cnt=0.
- sign = 1 when fan_speed >= 2, else 0. Updates in the same cycle as fan_speed.
- enable low: state, fan_speed, alarm and seed are held. dwell_cnt and crit_cnt clear. rollover_flag is ignored.
- rollover_flag asserted on consecutive cycles: each cycle counts as a separate sample.
- Reset asserted mid-operation, including in ALARM: all registers return to reset values immediately (asynchronous).
- Width rules:
  - Comparisons are unsigned 7-bit.
  - Threshold-minus-HYST is computed at elaboration; parameters must satisfy T_k >= HYST.
  - Counters are sized to $clog2(max(DWELL, CRIT_COUNT)+1).

Test Plan:
- Ramp up: reset, then samples of temperature 45, 65, 85 -> fan_speed 1, 2, 3 one cycle after each strobe; sign goes 0 -> 1 at level 2.
- Hysteresis hold: at LVL2, samples of 57 (>= 60-4=56) x6 -> remains LVL2. Then 55 x4 -> LVL1 after the 4th sample only. Then 55 x3 followed by 57 -> dwell_cnt clears, remains LVL1.
- Alarm entry: at LVL1, samples of 100, 101, 99, 100, 100, 100 -> the 99 breaks the run. ALARM is entered after the 6th sample: alarm=1, fan_speed=3, rollover_val=25, seed=6.
- Alarm exit: in ALARM, sample 80 -> stays in ALARM. Sample 75 -> LVL3, alarm=0, rollover_val=50, seed remains 6.
- Enable/strobe gating: enable=0 with strobes at temperature 90 -> no change. rollover_flag=0 with temperature 90 -> no change. enable=1 with strobe -> one step up.
- Async reset in ALARM: assert rst between clock edges -> fan_speed=0, alarm=0, seed=5, rollover_val=50 before the next clk edge.
